// File: rtl/serial_addsub_ctrl_if.sv
// Handshake/data bundle for the bit-serial adder/subtractor.
// Master issues operands; slave returns status and result.
interface serial_addsub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, ovf
    );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract: one full-add cell, LSB first.
// IDLE -> RUN (WIDTH cycles) -> DONE (1 cycle) -> IDLE.
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_addsub_ctrl_if.slave  bus
);
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             bit_a;
    logic             bit_b;
    logic             sum_bit;
    logic             carry_nx;

    // State and datapath registers; reset discards any partial operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Full-add cell for the current bit plus next-state sequencing
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        bit_a    = a_q[idx_q];
        bit_b    = b_q[idx_q] ^ sub_q;
        sum_bit  = bit_a ^ bit_b ^ carry_q;
        carry_nx = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    sub_d    = bus.sub;
                    idx_d    = '0;
                    carry_d  = bus.sub;
                    result_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                result_d[idx_q] = sum_bit;
                carry_d         = carry_nx;
                idx_d           = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    cout_d  = carry_nx;
                    ovf_d   = carry_q ^ carry_nx;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
endmodule
